// File: rtl/nbit_seq_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter, at most STEP bits per clock, valid/ready on both sides.
// Optional feature macro: ROTATE_EN (op=11 becomes rotate-right; otherwise op=11 decodes as SRL).
module nbit_seq_shifter #(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         result
);

  localparam int W = $clog2(N);
  // Shifts never exceed N-1 in total, so a single step never needs more than that.
  localparam int SMAX = (STEP < N) ? STEP : (N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_result;
  logic [1:0]   r_op;
  logic         r_sign;
  logic [W-1:0] r_remaining;

  logic [W-1:0] w_s;
  logic         w_fill;
  logic [N-1:0] w_ones;
  logic [N-1:0] w_cand;
  logic [N-1:0] w_next;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;

  // One step of the datapath: only the constant shifts 1..SMAX exist, selected by w_s.
  always_comb begin
    w_s    = (r_remaining > W'(SMAX)) ? W'(SMAX) : r_remaining;
    w_fill = (r_op == 2'b10) ? r_sign : 1'b0;
    w_ones = '1;
    w_cand = r_result;
    w_next = r_result;
    for (int k = 1; k <= SMAX; k++) begin
      case (r_op)
        2'b00: w_cand = r_result << k;
`ifdef ROTATE_EN
        2'b11: w_cand = (r_result >> k) | (r_result << (N - k));
`endif
        default: w_cand = (r_result >> k) | (~(w_ones >> k) & {N{w_fill}});
      endcase
      w_next = (w_s == W'(k)) ? w_cand : w_next;
    end
  end

  // Control FSM and result register; flush outranks both handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_op        <= 2'b00;
      r_sign      <= 1'b0;
      r_remaining <= '0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_result    <= a;
            r_op        <= op;
            r_sign      <= a[N-1];
            r_remaining <= shamt;
            r_state     <= (shamt != '0) ? ST_SHIFT : ST_DONE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_result    <= w_next;
          r_remaining <= r_remaining - w_s;
          r_state     <= (r_remaining == w_s) ? ST_DONE : ST_SHIFT;
        end
        ST_DONE: begin
          r_state <= out_ready ? ST_IDLE : ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
